// File: rtl/ascon_perm_ctrl.sv
// Sequencing controller for the Ascon-128 permutation datapath.
// Drives state load, round enable/index and key/data XOR strobes for init, absorb and finalization.
module ascon_perm_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_data_valid,
  input  logic       i_data_last,
  output logic       o_data_ready,
  output logic       o_load_init,
  output logic       o_perm_en,
  output logic [3:0] o_round,
  output logic       o_enable_xor_data,
  output logic       o_enable_xor_key,
  output logic       o_enable_xor_key_end,
  output logic       o_busy,
  output logic       o_done
);

  generate
    if (ROUNDS_A != 12 || ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds
      $error("ascon_perm_ctrl: ROUNDS_A must be 12 and ROUNDS_B must be 1..12");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] B_FIRST    = 4'(12 - ROUNDS_B);
  localparam logic [3:0] B_SECOND   = 4'(13 - ROUNDS_B);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    WAIT_DATA,
    ABSORB,
    FINAL,
    DONE
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       last_q, last_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      last_q <= last_next;
    end
  end

  // The handshake cycle in WAIT_DATA doubles as the first B round, so data inputs feed the outputs there.
  always_comb begin
    state_next           = state;
    cnt_next             = cnt;
    last_next            = last_q;
    o_data_ready         = 1'b0;
    o_load_init          = 1'b0;
    o_perm_en            = 1'b0;
    o_round              = 4'd0;
    o_enable_xor_data    = 1'b0;
    o_enable_xor_key     = 1'b0;
    o_enable_xor_key_end = 1'b0;
    o_busy               = (state != IDLE);
    o_done               = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) state_next = LOAD;
      end

      LOAD: begin
        o_load_init = 1'b1;
        cnt_next    = 4'd0;
        state_next  = INIT;
      end

      INIT: begin
        o_perm_en = 1'b1;
        o_round   = cnt;
        if (cnt == LAST_ROUND) begin
          o_enable_xor_key_end = 1'b1;
          state_next           = WAIT_DATA;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      WAIT_DATA: begin
        o_data_ready = 1'b1;
        if (i_data_valid) begin
          o_perm_en         = 1'b1;
          o_enable_xor_data = 1'b1;
          o_round           = B_FIRST;
          last_next         = i_data_last;
          if (ROUNDS_B == 1) begin
            if (i_data_last) begin
              state_next = FINAL;
              cnt_next   = 4'd0;
            end
          end else begin
            state_next = ABSORB;
            cnt_next   = B_SECOND;
          end
        end
      end

      ABSORB: begin
        o_perm_en = 1'b1;
        o_round   = cnt;
        if (cnt == LAST_ROUND) begin
          if (last_q) begin
            state_next = FINAL;
            cnt_next   = 4'd0;
          end else begin
            state_next = WAIT_DATA;
          end
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      FINAL: begin
        o_perm_en        = 1'b1;
        o_round          = cnt;
        o_enable_xor_key = (cnt == 4'd0);
        if (cnt == LAST_ROUND) begin
          o_enable_xor_key_end = 1'b1;
          state_next           = DONE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl with ROUNDS_B = 6: stimulus pushes the expected
// output vector for each cycle, a separate monitor pops and compares on the falling edge.
module tb_ascon_perm_ctrl;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic       i_data_valid;
  logic       i_data_last;
  logic       o_data_ready;
  logic       o_load_init;
  logic       o_perm_en;
  logic [3:0] o_round;
  logic       o_enable_xor_data;
  logic       o_enable_xor_key;
  logic       o_enable_xor_key_end;
  logic       o_busy;
  logic       o_done;

  typedef struct packed {
    logic       ready;
    logic       load;
    logic       perm;
    logic [3:0] round;
    logic       xd;
    logic       xk;
    logic       xke;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } item_t;

  item_t sb_q[$];
  int    tests_run = 0;
  int    failures  = 0;

  ascon_perm_ctrl #(
    .ROUNDS_A(12),
    .ROUNDS_B(6)
  ) dut (
    .i_clk               (clk),
    .i_rst               (i_rst),
    .i_start             (i_start),
    .i_data_valid        (i_data_valid),
    .i_data_last         (i_data_last),
    .o_data_ready        (o_data_ready),
    .o_load_init         (o_load_init),
    .o_perm_en           (o_perm_en),
    .o_round             (o_round),
    .o_enable_xor_data   (o_enable_xor_data),
    .o_enable_xor_key    (o_enable_xor_key),
    .o_enable_xor_key_end(o_enable_xor_key_end),
    .o_busy              (o_busy),
    .o_done              (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(bit ready, bit load, bit perm, int round,
                              bit xd, bit xk, bit xke, bit busy, bit done);
    out_t v;
    v.ready = ready;
    v.load  = load;
    v.perm  = perm;
    v.round = 4'(round);
    v.xd    = xd;
    v.xk    = xk;
    v.xke   = xke;
    v.busy  = busy;
    v.done  = done;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge and record what that cycle must show.
  task automatic applyStimulus(input bit rst, input bit start, input bit valid, input bit last,
                               input bit chk, input out_t e, input string name);
    item_t it;
    @(posedge clk);
    #1;
    i_rst        = rst;
    i_start      = start;
    i_data_valid = valid;
    i_data_last  = last;
    if (chk) begin
      it.exp  = e;
      it.name = name;
      sb_q.push_back(it);
    end
  endtask

  task automatic checkOutput(input item_t it);
    out_t act;
    act = {o_data_ready, o_load_init, o_perm_en, o_round, o_enable_xor_data,
           o_enable_xor_key, o_enable_xor_key_end, o_busy, o_done};
    tests_run++;
    if (act !== it.exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got rdy/ld/pe/rnd/xd/xk/xke/bsy/dn=%b expected %b",
               it.name, $time, act, it.exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, '0, name);
  endtask

  task automatic do_init();
    applyStimulus(0, 1, 0, 0, 1, '0, "idle_start");
    applyStimulus(0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 1, 0), "load");
    for (int k = 0; k < 12; k++)
      applyStimulus(0, 0, 0, 0, 1, mk(0, 0, 1, k, 0, 0, k == 11, 1, 0), "init_round");
  endtask

  task automatic do_block(input bit last, input bit hold_valid);
    applyStimulus(0, 0, 1, last, 1, mk(1, 0, 1, 6, 1, 0, 0, 1, 0), "handshake");
    for (int k = 7; k < 12; k++)
      applyStimulus(0, 0, hold_valid, 0, 1, mk(0, 0, 1, k, 0, 0, 0, 1, 0), "absorb_round");
  endtask

  task automatic do_stall(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, (i % 3) == 0, 0, 1, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 0), "stall");
  endtask

  // abort_round < 0 runs finalization to completion; otherwise reset is asserted in that round.
  task automatic do_final(input int abort_round);
    for (int k = 0; k < 12; k++) begin
      if (k == abort_round) begin
        applyStimulus(1, 0, 0, 0, 1, mk(0, 0, 1, k, 0, k == 0, k == 11, 1, 0), "final_abort");
        idle_cycles(3, "post_abort_idle");
        return;
      end
      applyStimulus(0, 0, 0, 0, 1, mk(0, 0, 1, k, 0, k == 0, k == 11, 1, 0), "final_round");
    end
    applyStimulus(0, 1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "done");
    idle_cycles(2, "idle_after_done");
  endtask

  initial begin
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, '0, "");
    applyStimulus(1, 0, 0, 0, 1, '0, "reset_outputs");
    idle_cycles(5, "reset_idle");

    applyStimulus(1, 1, 0, 0, 1, '0, "rst_with_start");
    idle_cycles(2, "reset_wins");

    $display("[TB] single-block message");
    do_init();
    do_block(1, 0);
    do_final(-1);

    $display("[TB] three back-to-back blocks");
    do_init();
    do_block(0, 1);
    do_block(0, 1);
    do_block(1, 0);
    do_final(-1);

    $display("[TB] host stalls with start pulses while busy");
    do_init();
    do_stall(10);
    do_block(0, 0);
    do_stall(2);
    do_block(1, 0);
    do_final(-1);

    $display("[TB] reset during finalization then replay");
    do_init();
    do_block(1, 0);
    do_final(5);
    do_init();
    do_block(1, 0);
    do_final(-1);

    applyStimulus(0, 0, 0, 0, 0, '0, "");
    applyStimulus(0, 0, 0, 0, 0, '0, "");
    @(negedge clk);
    #1;
    tests_run++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
